cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Arbitrates the common data bus (CDB) between the six result producers: ADD1, ADD2, ADD3, MULT1, MULT2 and the load/store unit.
- Accepts at most one result per cycle through a valid/ready handshake.
- Registers the winning result and broadcasts it with its station tag and ROB index to the reorder buffer and the reservation stations.
- Holds the broadcast while the consumers assert stall.

## Interface
Parameters:
- DATA_W, 32, result width
- NREQ, 6, requester count, fixed order 0=ADD1, 1=ADD2, 2=ADD3, 3=MULT1, 4=MULT2, 5=LS

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst_n  input  1  synchronous, active-high reset (port keeps the codebase name)
- req_valid  input  6  per-requester result valid
- req_ready  output  6  per-requester grant/accept, combinational
- req_data  input  192  flattened results, requester i at bits [32i+31:32i]
- req_rob_idx  input  18  flattened 3-bit ROB entry index per requester
- ls_idx  input  3  LS unit station code, used as its tag
- cdb_stall  input  1  consumers cannot take the current broadcast
- flush  input  1  discard the pending broadcast (mispredict recovery)
- cdb_valid  output  1  broadcast valid, registered
- cdb_tag  output  4  source station code: ADD1=7, ADD2=8, ADD3=9, MULT1=10, MULT2=11, LS={1'b0,ls_idx}
- cdb_rob_idx  output  3  ROB entry of the broadcast result
- cdb_data  output  32  broadcast result
- grant_cnt  output  16  accepted transfers since reset, saturating at 16'hFFFF

## Operation
- Output register has two states:
  - EMPTY (cdb_valid=0)
  - FULL (cdb_valid=1)
- load_en = ~cdb_valid | ~cdb_stall. The register may accept a new result when load_en is high.
- Grant: when load_en is high, exactly one requester with req_valid=1 gets req_ready=1. The winner is chosen by the priority rule (see Configuration).
- When load_en is low, req_ready is all zero.
- Transfer occurs on valid&ready in the same cycle. Next cycle: cdb_valid=1 and cdb_tag/cdb_rob_idx/cdb_data reflect the winner.
- The requester must hold its valid, data and rob_idx until it is accepted. The arbiter never drops an accepted result.
- FULL and stalled: the output holds every field stable and no grant is issued.
- FULL, not stalled, no request: cdb_valid goes to 0 next cycle (EMPTY).
- FULL, not stalled, with a request: back-to-back transfer; cdb_valid stays 1 and the fields are replaced.
- flush=1:
  - cdb_valid is forced to 0 next cycle.
  - req_ready is all zero in the flush cycle.
  - flush has priority over stall and over a new grant.
  - The round-robin pointer and grant_cnt are unchanged.
- ls_idx is sampled at the grant cycle, together with the LS data.
- grant_cnt increments by 1 per transfer and does not wrap at 16'hFFFF.

## Timing
- Latency is 1 cycle from the accept edge to cdb_valid.
- Throughput is one broadcast per cycle while not stalled.
- req_ready depends combinationally on req_valid, cdb_valid, cdb_stall and flush. There is no combinational path from req_data to any output.
- Reset values: cdb_valid=0, cdb_tag=0, cdb_rob_idx=0, cdb_data=0, grant_cnt=0, round-robin pointer=0 (ADD1 highest priority).
- Reset asserted mid-broadcast clears the broadcast on the next edge. The pending result is lost, and the requesters are reset alongside.
- Stall asserted on the same cycle cdb_valid first rises: the data holds from that cycle onward.

## Configuration
- CDB_RR_EN defined: round-robin arbitration.
  - The pointer p marks the highest-priority requester.
  - The winner is the first valid requester scanning p, p+1, ..., wrapping 5->0.
  - After a transfer from requester i, p = (i+1) mod 6.
  - p does not move without a transfer.
  - Any continuously-valid requester is granted within 6 transfers.
- CDB_RR_EN undefined: fixed priority LS > MULT1 > MULT2 > ADD1 > ADD2 > ADD3.
  - No pointer register exists.
  - Starvation of low-priority units is permitted.

## Test plan
- Reset, then ADD1 valid with data 32'h0000_00AA, rob 3 -> next cycle cdb_valid=1, tag=7, rob_idx=3, data=32'hAA, grant_cnt=1.
- All six valid continuously, CDB_RR_EN defined -> grant order ADD1, ADD2, ADD3, MULT1, MULT2, LS, ADD1. Tags 7,8,9,10,11,ls_idx,7 on consecutive cycles.
- Same stimulus with CDB_RR_EN undefined -> LS granted every cycle with tag={0,ls_idx}; the other req_ready stay 0.
- MULT2 broadcast (tag 11, data 32'h1234_5678), cdb_stall high for 3 cycles while ADD2 is valid -> output stable for 3 cycles, req_ready=0. ADD2 is granted in the cycle stall drops and broadcast (tag 8) the following cycle.
- Broadcast pending with stall high, then flush=1 -> cdb_valid=0 next cycle, no grant in the flush cycle, pointer unchanged.
- Preload grant_cnt to 16'hFFFE via 65534 transfers, then 2 more transfers -> grant_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the result-producer handshake and the common data bus broadcast.
//
// Signals:
//   req_valid   [NREQ]         per-requester result valid (producer -> arbiter)
//   req_ready   [NREQ]         per-requester accept       (arbiter -> producer)
//   req_data    [NREQ*DATA_W]  flattened results, requester i at [DATA_W*i +: DATA_W]
//   req_rob_idx [NREQ*3]       flattened 3-bit ROB index per requester
//   ls_idx      [3]            LS unit station code, used as its tag
//   cdb_stall                  consumers cannot take the current broadcast
//   cdb_valid                  broadcast valid
//   cdb_tag     [4]            source station code
//   cdb_rob_idx [3]            ROB entry of the broadcast result
//   cdb_data    [DATA_W]       broadcast result
//
// Modports:
//   slave  - arbiter side
//   master - producer / consumer side
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 6
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*3-1:0]      req_rob_idx;
  logic [2:0]             ls_idx;
  logic                   cdb_stall;
  logic                   cdb_valid;
  logic [3:0]             cdb_tag;
  logic [2:0]             cdb_rob_idx;
  logic [DATA_W-1:0]      cdb_data;

  modport slave (
    input  req_valid, req_data, req_rob_idx, ls_idx, cdb_stall,
    output req_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_data
  );

  modport master (
    output req_valid, req_data, req_rob_idx, ls_idx, cdb_stall,
    input  req_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates the common data bus between six result producers (0=ADD1, 1=ADD2,
// 2=ADD3, 3=MULT1, 4=MULT2, 5=LS), accepts at most one result per cycle and
// broadcasts it from a register, holding it while the consumers stall.
//
// Configuration macro:
//   CDB_RR_EN  defined   -> round-robin arbitration with a rotating pointer
//              undefined -> fixed priority LS > MULT1 > MULT2 > ADD1 > ADD2 > ADD3
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous reset, ACTIVE-HIGH despite the name
//   flush      drop the pending broadcast, block grants this cycle
//   grant_cnt  accepted transfers since reset, saturating at 16'hFFFF
//   bus        cdb_arbiter_if.slave: request handshake and CDB broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREQ   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic [15:0]   grant_cnt,
  cdb_arbiter_if.slave  bus
);

  localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [3:0]        tag_q, tag_d;
  logic [2:0]        rob_q, rob_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              load_en;
  logic              grant_ok;
  logic              xfer;
  logic              win_any;
  logic [2:0]        win_idx;

  function automatic logic [3:0] station_tag(input logic [2:0] idx,
                                             input logic [2:0] ls);
    logic [3:0] t;
    case (idx)
      3'd0:    t = 4'd7;
      3'd1:    t = 4'd8;
      3'd2:    t = 4'd9;
      3'd3:    t = 4'd10;
      3'd4:    t = 4'd11;
      default: t = {1'b0, ls};
    endcase
    return t;
  endfunction

  // The output register can take a new result when it is empty or draining.
  assign load_en  = (state_q == EMPTY) | ~bus.cdb_stall;
  assign grant_ok = load_en & ~flush;
  assign xfer     = grant_ok & win_any;

`ifdef CDB_RR_EN
  localparam logic [3:0] NREQ4 = 4'(NREQ);

  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cand;

  // Scan from the farthest candidate back toward the pointer so the last hit
  // is the first valid requester at or after the pointer.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= NREQ4) cand = cand - NREQ4;
      if (bus.req_valid[cand[2:0]]) begin
        win_any = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_any = |bus.req_valid;
    win_idx = '0;
    if      (bus.req_valid[5]) win_idx = 3'd5;
    else if (bus.req_valid[3]) win_idx = 3'd3;
    else if (bus.req_valid[4]) win_idx = 3'd4;
    else if (bus.req_valid[0]) win_idx = 3'd0;
    else if (bus.req_valid[1]) win_idx = 3'd1;
    else if (bus.req_valid[2]) win_idx = 3'd2;
  end
`endif

  // ---- accept stage -> broadcast register ----
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Flush wins over both a held (stalled) broadcast and a fresh grant.
  always_comb begin
    state_d = state_q;
    if (flush)        state_d = EMPTY;
    else if (xfer)    state_d = FULL;
    else if (load_en) state_d = EMPTY;
  end

  always_comb begin
    bus.cdb_valid = (state_q == FULL);
    bus.req_ready = xfer ? (REQ_ONE << win_idx) : '0;
  end

  always_comb begin
    tag_d  = tag_q;
    rob_d  = rob_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      tag_d  = station_tag(win_idx, bus.ls_idx);
      rob_d  = bus.req_rob_idx[win_idx*3 +: 3];
      data_d = bus.req_data[win_idx*DATA_W +: DATA_W];
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tag_q  <= '0;
      rob_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      tag_q  <= tag_d;
      rob_q  <= rob_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.cdb_tag     = tag_q;
  assign bus.cdb_rob_idx = rob_q;
  assign bus.cdb_data    = data_q;
  assign grant_cnt       = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A behavioural model tracks the expected
// broadcast, pointer and transfer count from the arbitration rules; directed
// scenarios and a randomized producer/consumer run are checked against it.
// Works with CDB_RR_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] grant_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .grant_cnt(grant_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_valid;
  logic [3:0]  m_tag;
  logic [2:0]  m_rob;
  logic [31:0] m_data;
  int          m_ptr;
  int          m_cnt;

  // Winner among valid requesters per the arbitration rule, -1 if none.
  function automatic int pick(input logic [5:0] v, input int p);
`ifdef CDB_RR_EN
    for (int k = 0; k < 6; k++)
      if (v[(p + k) % 6]) return (p + k) % 6;
`else
    int ord[6] = '{5, 3, 4, 0, 1, 2};
    for (int k = 0; k < 6; k++)
      if (v[ord[k]]) return ord[k];
`endif
    return -1;
  endfunction

  function automatic logic [3:0] tag_of(input int i, input logic [2:0] ls);
    if (i == 5) return {1'b0, ls};
    return 4'(7 + i);
  endfunction

  function automatic int model_winner();
    int w;
    if (m_valid && bus.cdb_stall) return -1;
    if (flush) return -1;
    w = pick(bus.req_valid, m_ptr);
    return w;
  endfunction

  function automatic logic [5:0] exp_ready();
    int w;
    w = model_winner();
    if (w < 0) return 6'd0;
    return 6'd1 << w;
  endfunction

  // Advance one clock; update the model from the inputs seen before the edge.
  task automatic tick(output int w);
    bit le;
    le = !m_valid || !bus.cdb_stall;
    w  = rst_n ? -1 : model_winner();
    @(posedge clk);
    if (rst_n) begin
      m_valid = 0; m_tag = 0; m_rob = 0; m_data = 0; m_ptr = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (w >= 0) begin
      m_valid = 1;
      m_tag   = tag_of(w, bus.ls_idx);
      m_rob   = bus.req_rob_idx[w*3 +: 3];
      m_data  = bus.req_data[w*32 +: 32];
      m_ptr   = (w + 1) % 6;
      if (m_cnt < 65535) m_cnt++;
    end else if (le) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_rob_idx = '0;
    bus.ls_idx      = '0;
    bus.cdb_stall   = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] r);
    bus.req_valid[i]          = 1'b1;
    bus.req_data[i*32 +: 32]  = d;
    bus.req_rob_idx[i*3 +: 3] = r;
  endtask

  task automatic do_reset();
    int w;
    clear_inputs();
    rst_n = 1'b1;
    tick(w);
    tick(w);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    int w;
    clear_inputs();
    rst_n = 1'b1;
    tick(w);
    rst_n = 1'b0;
    set_req(4, 32'hDEAD_BEEF, 3'd6);
    tick(w);
    // broadcast in flight, then reset hits it
    rst_n = 1'b1;
    tick(w);
    clear_inputs();
    tick(w);
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
    n_chk++; if (bus.cdb_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", bus.cdb_tag); end
    n_chk++; if (bus.cdb_rob_idx !== 3'd0) begin n_fail++; $display("FAIL reset_rob: got %0d want 0", bus.cdb_rob_idx); end
    n_chk++; if (bus.cdb_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.cdb_data); end
    n_chk++; if (grant_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", grant_cnt); end
    n_chk++; if (bus.req_ready !== 6'd0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
  endtask

  task automatic test_single();
    int w;
    set_req(0, 32'h0000_00AA, 3'd3);
    #1;
    n_chk++; if (bus.req_ready !== 6'b000001) begin n_fail++; $display("FAIL single_ready: got %b want 000001", bus.req_ready); end
    tick(w);
    bus.req_valid = '0;
    n_chk++; if (bus.cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.cdb_valid); end
    n_chk++; if (bus.cdb_tag !== 4'd7) begin n_fail++; $display("FAIL single_tag: got %0d want 7", bus.cdb_tag); end
    n_chk++; if (bus.cdb_rob_idx !== 3'd3) begin n_fail++; $display("FAIL single_rob: got %0d want 3", bus.cdb_rob_idx); end
    n_chk++; if (bus.cdb_data !== 32'hAA) begin n_fail++; $display("FAIL single_data: got %h want aa", bus.cdb_data); end
    n_chk++; if (grant_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", grant_cnt); end
    #1;
    tick(w);
    n_chk++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", bus.cdb_valid); end
  endtask

  task automatic test_all_valid();
    int w;
    int exp_w;
    logic [2:0] ls;
    logic [3:0] exp_tag;
    do_reset();
    ls = 3'($urandom_range(0, 6));
    bus.ls_idx = ls;
    for (int i = 0; i < 6; i++) set_req(i, 32'h1111_1111 * (i + 1), 3'(i));
    for (int k = 0; k < 7; k++) begin
`ifdef CDB_RR_EN
      exp_w = k % 6;
`else
      exp_w = 5;
`endif
      exp_tag = (exp_w == 5) ? {1'b0, ls} : 4'(7 + exp_w);
      #1;
      n_chk++; if (bus.req_ready !== (6'd1 << exp_w)) begin n_fail++; $display("FAIL allv_ready[%0d]: got %b want %b", k, bus.req_ready, 6'd1 << exp_w); end
      tick(w);
      n_chk++; if (bus.cdb_tag !== exp_tag) begin n_fail++; $display("FAIL allv_tag[%0d]: got %0d want %0d", k, bus.cdb_tag, exp_tag); end
      n_chk++; if (bus.cdb_data !== 32'h1111_1111 * (exp_w + 1)) begin n_fail++; $display("FAIL allv_data[%0d]: got %h want %h", k, bus.cdb_data, 32'h1111_1111 * (exp_w + 1)); end
    end
    n_chk++; if (grant_cnt !== 16'd7) begin n_fail++; $display("FAIL allv_cnt: got %0d want 7", grant_cnt); end
  endtask

  task automatic test_stall();
    int w;
    do_reset();
    set_req(4, 32'h1234_5678, 3'd5);
    #1;
    tick(w);
    bus.req_valid[4] = 1'b0;
    set_req(1, 32'hBEEF_0001, 3'd2);
    bus.cdb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (bus.req_ready !== 6'd0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", k, bus.req_ready); end
      n_chk++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd11 || bus.cdb_rob_idx !== 3'd5)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b tag=%0d rob=%0d want v=1 tag=11 rob=5", k, bus.cdb_valid, bus.cdb_tag, bus.cdb_rob_idx); end
      n_chk++; if (bus.cdb_data !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want 12345678", k, bus.cdb_data); end
      tick(w);
    end
    bus.cdb_stall = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 6'b000010) begin n_fail++; $display("FAIL stall_release_ready: got %b want 000010", bus.req_ready); end
    tick(w);
    bus.req_valid[1] = 1'b0;
    n_chk++; if (bus.cdb_tag !== 4'd8 || bus.cdb_data !== 32'hBEEF_0001 || bus.cdb_rob_idx !== 3'd2)
      begin n_fail++; $display("FAIL stall_next: got tag=%0d data=%h rob=%0d want tag=8 data=beef0001 rob=2", bus.cdb_tag, bus.cdb_data, bus.cdb_rob_idx); end
  endtask

  task automatic test_flush();
    int w;
    do_reset();
    set_req(2, 32'h0000_A5A5, 3'd1);
    #1;
    tick(w);
    bus.req_valid[2] = 1'b0;
    bus.cdb_stall = 1'b1;
    set_req(0, 32'h0000_0C0C, 3'd4);
    #1;
    tick(w);
    n_chk++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd9) begin n_fail++; $display("FAIL flush_pre: got v=%b tag=%0d want v=1 tag=9", bus.cdb_valid, bus.cdb_tag); end
    flush = 1'b1;
    bus.cdb_stall = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 6'd0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.req_ready); end
    tick(w);
    flush = 1'b0;
    n_chk++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.cdb_valid); end
    n_chk++; if (grant_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d want 1", grant_cnt); end
    // ADD2 and MULT1 pending: pointer still just past ADD3 picks MULT1
    bus.req_valid = '0;
    set_req(1, 32'h0000_0001, 3'd0);
    set_req(3, 32'h0000_0003, 3'd7);
    #1;
    n_chk++; if (bus.req_ready !== 6'b001000) begin n_fail++; $display("FAIL flush_ptr_ready: got %b want 001000", bus.req_ready); end
    tick(w);
    bus.req_valid = '0;
    n_chk++; if (bus.cdb_tag !== 4'd10 || bus.cdb_rob_idx !== 3'd7) begin n_fail++; $display("FAIL flush_ptr_tag: got tag=%0d rob=%0d want 10/7", bus.cdb_tag, bus.cdb_rob_idx); end
  endtask

  task automatic test_random();
    int w;
    logic [5:0] pend;
    logic [5:0] er;
    bit do_rst;
    do_reset();
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      do_rst        = ($urandom % 100) == 0;
      rst_n         = do_rst;
      bus.cdb_stall = ($urandom % 10) < 3;
      flush         = ($urandom % 20) == 0;
      bus.ls_idx    = 3'($urandom);
      for (int i = 0; i < 6; i++) begin
        if (!pend[i] && ($urandom % 2)) begin
          pend[i] = 1'b1;
          bus.req_data[i*32 +: 32]  = $urandom;
          bus.req_rob_idx[i*3 +: 3] = 3'($urandom);
        end
      end
      bus.req_valid = pend;
      #1;
      if (!do_rst) begin
        er = exp_ready();
        n_chk++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, er); end
      end
      tick(w);
      if (do_rst) pend = '0;
      else if (w >= 0) pend[w] = 1'b0;
      n_chk++; if (bus.cdb_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.cdb_valid, m_valid); end
      if (m_valid) begin
        n_chk++; if (bus.cdb_tag !== m_tag || bus.cdb_rob_idx !== m_rob || bus.cdb_data !== m_data)
          begin n_fail++; $display("FAIL rand_bcast[%0d]: got %0d/%0d/%h want %0d/%0d/%h", c, bus.cdb_tag, bus.cdb_rob_idx, bus.cdb_data, m_tag, m_rob, m_data); end
      end
      n_chk++; if (grant_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, grant_cnt, m_cnt); end
    end
    rst_n = 1'b0;
  endtask

  task automatic test_saturate();
    int w;
    do_reset();
    for (int i = 0; i < 6; i++) set_req(i, 32'(i), 3'(i));
    repeat (65534) tick(w);
    n_chk++; if (grant_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", grant_cnt); end
    tick(w);
    tick(w);
    n_chk++; if (grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", grant_cnt); end
    tick(w);
    n_chk++; if (grant_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", grant_cnt); end
    n_chk++; if (grant_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL sat_model: got %h want %h", grant_cnt, 16'(m_cnt)); end
  endtask

  initial begin
    m_valid = 0; m_tag = 0; m_rob = 0; m_data = 0; m_ptr = 0; m_cnt = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_all_valid();
    test_stall();
    test_flush();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
